program_loader: RTL and testbench

Writes a program image into the instruction RAM and then hands the RAM to the processor. It accepts a valid/ready stream of 32-bit instruction words, drives the processor's `addr`/`wr`/`wdata` load port at consecutive addresses from 0, and asserts `working` once the last word has been committed. It replaces the hand-sequenced testbench load and sits between a host/UART front end and `processor`.

---
 rtl/processor_pkg.sv | 6 +
 rtl/program_loader.sv | 105 ++++++++++
 tb/tb_program_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// processor_pkg: widths shared by the RAM, processor and program loader, plus the loader state encoding.
package processor_pkg;
    localparam int LOADER_ADDR_W = 9;
    localparam int LOADER_DATA_W = 32;
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SETTLE, ST_RUN, ST_ERR} loader_state_t;
endpackage

// File: rtl/program_loader.sv
// program_loader: streams an instruction image into RAM from address 0, then enables the processor.
module program_loader
    import processor_pkg::*;
#(
    parameter int ADDR_W = LOADER_ADDR_W,
    parameter int DATA_W = LOADER_DATA_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              halt,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              wr,
    output logic [DATA_W-1:0] wdata,
    output logic              working,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);
    localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);
    loader_state_t     state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic              wr_n, working_n, error_n;
    logic [DATA_W-1:0] wdata_n;
    logic [ADDR_W:0]   count_n;
    assign in_ready = (state == ST_LOAD);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_n;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr       <= '0;
            wr         <= 1'b0;
            wdata      <= '0;
            working    <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            addr       <= addr_n;
            wr         <= wr_n;
            wdata      <= wdata_n;
            working    <= working_n;
            error      <= error_n;
            word_count <= count_n;
        end
    end
    // halt overrides everything, including a beat offered in the same cycle
    always_comb begin
        state_n   = state;
        addr_n    = addr;
        wr_n      = 1'b0;
        wdata_n   = wdata;
        working_n = working;
        error_n   = error;
        count_n   = word_count;
        if (halt) begin
            state_n   = ST_IDLE;
            working_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    working_n = 1'b0;
                    if (load_start) begin
                        state_n = ST_LOAD;
                        count_n = '0;
                        error_n = 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        addr_n  = word_count[ADDR_W-1:0];
                        wdata_n = in_data;
                        wr_n    = 1'b1;
                        count_n = word_count + (ADDR_W+1)'(1);
                        if (in_last) state_n = ST_SETTLE;
                        else if (word_count == LAST_SLOT) begin
                            state_n = ST_ERR;
                            error_n = 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    addr_n    = '0;
                    working_n = 1'b1;
                    state_n   = ST_RUN;
                end
                ST_RUN: working_n = 1'b1;
                ST_ERR: begin
                    working_n = 1'b0;
                    if (load_start) begin
                        state_n = ST_LOAD;
                        count_n = '0;
                        error_n = 1'b0;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven check of program_loader plus overflow, full-image and async-reset sequences.
module tb_program_loader;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_start = 1'b0, halt = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, wr, working, error;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [9:0]  word_count;
    int nvec = 0;
    int nmis = 0;

    program_loader dut (
        .clock(clock), .reset_n(reset_n), .load_start(load_start), .halt(halt),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .addr(addr), .wr(wr), .wdata(wdata), .working(working), .error(error),
        .word_count(word_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ls, h, v;
        logic [31:0] d;
        logic        last;
        logic [54:0] exp;
    } vec_t;

    function automatic logic [54:0] pk(input logic rdy, input logic w, input logic [8:0] a,
                                       input logic [31:0] wd, input logic wk, input logic er,
                                       input logic [9:0] cnt);
        return {rdy, w, a, wd, wk, er, cnt};
    endfunction

    function automatic vec_t mk(input logic ls, input logic h, input logic v, input logic [31:0] d,
                                input logic last, input logic [54:0] exp);
        vec_t r;
        r.ls = ls; r.h = h; r.v = v; r.d = d; r.last = last; r.exp = exp;
        return r;
    endfunction

    task automatic drive(input logic ls, input logic h, input logic v, input logic [31:0] d, input logic last);
        load_start = ls; halt = h; in_valid = v; in_data = d; in_last = last;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [54:0] exp);
        logic [54:0] got;
        got = {in_ready, wr, addr, wdata, working, error, word_count};
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got rdy=%b wr=%b addr=%h wdata=%h working=%b error=%b count=%0d, want rdy=%b wr=%b addr=%h wdata=%h working=%b error=%b count=%0d",
                     name, got[54], got[53], got[52:44], got[43:12], got[11], got[10], got[9:0],
                     exp[54], exp[53], exp[52:44], exp[43:12], exp[11], exp[10], exp[9:0]);
        end
    endtask

    task automatic run_beats(input int n, input logic with_last);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'hA000_0000 + i, with_last && (i == n - 1));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    localparam logic [31:0] D0 = 32'h10f00010, D1 = 32'h20010000, D2 = 32'h21230000,
                            D3 = 32'h22450000, D4 = 32'h23670000;
    localparam logic [31:0] A = 32'h0000_00A1, B = 32'h0000_00B2, C = 32'h0000_00C3,
                            E = 32'h0000_00E5, F = 32'h0000_00F6, G = 32'h0000_0077, H = 32'h0000_0088;
    localparam logic [31:0] OV = 32'hA000_01FF;

    vec_t tab[26];

    initial begin
        tab[0]  = mk(1, 0, 0, 0,  0, pk(1, 0, 0, 0,  0, 0, 0));
        tab[1]  = mk(0, 0, 1, D0, 0, pk(1, 1, 0, D0, 0, 0, 1));
        tab[2]  = mk(0, 0, 1, D1, 0, pk(1, 1, 1, D1, 0, 0, 2));
        tab[3]  = mk(0, 0, 1, D2, 0, pk(1, 1, 2, D2, 0, 0, 3));
        tab[4]  = mk(0, 0, 1, D3, 0, pk(1, 1, 3, D3, 0, 0, 4));
        tab[5]  = mk(0, 0, 1, D4, 1, pk(0, 1, 4, D4, 0, 0, 5));
        tab[6]  = mk(0, 0, 0, 0,  0, pk(0, 0, 0, D4, 1, 0, 5));
        tab[7]  = mk(1, 0, 0, 0,  0, pk(0, 0, 0, D4, 1, 0, 5));
        tab[8]  = mk(1, 1, 0, 0,  0, pk(0, 0, 0, D4, 0, 0, 5));
        tab[9]  = mk(0, 0, 0, 0,  0, pk(0, 0, 0, D4, 0, 0, 5));
        tab[10] = mk(1, 0, 0, 0,  0, pk(1, 0, 0, D4, 0, 0, 0));
        tab[11] = mk(0, 0, 1, A,  0, pk(1, 1, 0, A,  0, 0, 1));
        tab[12] = mk(0, 0, 0, 0,  0, pk(1, 0, 0, A,  0, 0, 1));
        tab[13] = mk(0, 0, 1, B,  0, pk(1, 1, 1, B,  0, 0, 2));
        tab[14] = mk(0, 0, 0, 0,  0, pk(1, 0, 1, B,  0, 0, 2));
        tab[15] = mk(0, 0, 1, C,  1, pk(0, 1, 2, C,  0, 0, 3));
        tab[16] = mk(0, 0, 0, 0,  0, pk(0, 0, 0, C,  1, 0, 3));
        tab[17] = mk(0, 1, 0, 0,  0, pk(0, 0, 0, C,  0, 0, 3));
        tab[18] = mk(1, 0, 0, 0,  0, pk(1, 0, 0, C,  0, 0, 0));
        tab[19] = mk(0, 0, 1, E,  0, pk(1, 1, 0, E,  0, 0, 1));
        tab[20] = mk(0, 1, 1, F,  0, pk(0, 0, 0, E,  0, 0, 1));
        tab[21] = mk(1, 0, 0, 0,  0, pk(1, 0, 0, E,  0, 0, 0));
        tab[22] = mk(0, 0, 1, G,  0, pk(1, 1, 0, G,  0, 0, 1));
        tab[23] = mk(0, 0, 1, H,  1, pk(0, 1, 1, H,  0, 0, 2));
        tab[24] = mk(0, 0, 0, 0,  0, pk(0, 0, 0, H,  1, 0, 2));
        tab[25] = mk(0, 1, 0, 0,  0, pk(0, 0, 0, H,  0, 0, 2));

        #1 check("reset", '0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            drive(tab[i].ls, tab[i].h, tab[i].v, tab[i].d, tab[i].last);
            step();
            check($sformatf("vec%0d", i), tab[i].exp);
        end

        // overflow, then halt out of ERR keeps error set
        drive(1, 0, 0, 0, 0); step();
        run_beats(512, 1'b0);
        check("ovf_last_write", pk(0, 1, 9'h1ff, OV, 0, 1, 512));
        repeat (3) step();
        check("ovf_hold", pk(0, 0, 9'h1ff, OV, 0, 1, 512));
        drive(0, 1, 0, 0, 0); step();
        check("err_halt", pk(0, 0, 9'h1ff, OV, 0, 1, 512));
        drive(1, 0, 0, 0, 0); step();
        check("idle_restart", pk(1, 0, 9'h1ff, OV, 0, 0, 0));

        // second overflow, leave ERR directly with load_start
        run_beats(512, 1'b0);
        step();
        check("ovf2_hold", pk(0, 0, 9'h1ff, OV, 0, 1, 512));
        drive(1, 0, 0, 0, 0); step();
        check("err_restart", pk(1, 0, 9'h1ff, OV, 0, 0, 0));

        // full image: last beat exactly at DEPTH-1
        run_beats(512, 1'b1);
        check("full_last", pk(0, 1, 9'h1ff, OV, 0, 0, 512));
        step();
        check("full_run", pk(0, 0, 0, OV, 1, 0, 512));
        drive(0, 1, 0, 0, 0); step();
        check("full_halt", pk(0, 0, 0, OV, 0, 0, 512));

        // asynchronous reset between edges after 3 beats
        drive(1, 0, 0, 0, 0); step();
        run_beats(3, 1'b0);
        check("pre_rst", pk(1, 1, 2, 32'hA000_0002, 0, 0, 3));
        #2 reset_n = 1'b0;
        #1 check("async_rst", '0);
        step();
        check("rst_hold", '0);
        reset_n = 1'b1;
        drive(1, 0, 0, 0, 0); step();
        check("rst_reload", pk(1, 0, 0, 0, 0, 0, 0));
        drive(0, 0, 1, 32'h55, 0); step();
        check("rst_first_beat", pk(1, 1, 0, 32'h55, 0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
